isp_awb_gain_calc: RTL

- Gray-world auto-white-balance statistics and gain engine.
- Taps the RGB888 pixel stream on the same path that feeds the white-balance gain stage, and drives that stage's gain_r/gain_g/gain_b inputs.
- Accumulates per-channel sums over each frame. In vertical blanking it computes gain_r = sumG/sumR and gain_b = sumG/sumB in unsigned Q8.31; gain_g is fixed at unity.

---
 rtl/isp_awb_gain_calc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/isp_awb_gain_calc.sv
// Gray-world AWB: sums R/G/B over each frame, then divides in vblank to get Q8.31 gains.
// Optional ISP_AWB_SAT_EXCL_EN drops pixels with any component >= SAT_TH from all sums.
module isp_awb_gain_calc #(
  parameter int         WIDTH  = 1936,
  parameter int         HEIGHT = 1080,
  parameter int         ACC_W  = 32,
  parameter logic [7:0] SAT_TH = 8'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] per_img_data,
  input  logic        per_img_clken,
  input  logic        in_vsync,
  output logic [38:0] gain_r,
  output logic [38:0] gain_g,
  output logic [38:0] gain_b,
  output logic        gain_valid,
  output logic        busy
);

  localparam int               NUM_W     = ACC_W + 31;
  localparam int               CNT_W     = $clog2(NUM_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_W - 1);
  localparam logic [38:0]      GAIN_ONE  = 39'h0_8000_0000;
  localparam logic [38:0]      GAIN_MAX  = 39'h7F_FFFF_FFFF;

  if (64'(255) * 64'(WIDTH) * 64'(HEIGHT) >= (64'd1 << ACC_W)) begin : g_acc_chk
    $error("ACC_W too narrow for a full frame of 8-bit pixels");
  end
  if (SAT_TH == 8'd0) begin : g_sat_chk
    $error("SAT_TH of zero would exclude every pixel");
  end

  typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

  state_t             state, state_nxt;
  logic               vsync_d;
  logic               rise, fall, pix_en, last_step;
  logic [ACC_W-1:0]   sum_r, sum_g, sum_b;
  logic [ACC_W-1:0]   snap_r, snap_g, snap_b;
  logic [ACC_W-1:0]   rem, rem_nxt, den;
  logic [NUM_W-1:0]   dq, dq_nxt;
  logic [ACC_W:0]     trial, diff;
  logic               q_bit;
  logic [CNT_W-1:0]   cnt;
  logic [38:0]        res_r;

  assign rise = in_vsync & ~vsync_d;
  assign fall = ~in_vsync & vsync_d;

`ifdef ISP_AWB_SAT_EXCL_EN
  assign pix_en = in_vsync & per_img_clken &
                  (per_img_data[23:16] < SAT_TH) &
                  (per_img_data[15:8]  < SAT_TH) &
                  (per_img_data[7:0]   < SAT_TH);
`else
  assign pix_en = in_vsync & per_img_clken;
`endif

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] sum,
                                               input logic [7:0] comp);
    logic [ACC_W:0] t;
    t = {1'b0, sum} + {{(ACC_W-7){1'b0}}, comp};
    return t[ACC_W] ? {ACC_W{1'b1}} : t[ACC_W-1:0];
  endfunction

  function automatic logic [38:0] gain_of(input logic [NUM_W-1:0] q,
                                          input logic [ACC_W-1:0] d);
    if (d == '0)
      return GAIN_ONE;
    else if (|q[NUM_W-1:39])
      return GAIN_MAX;
    else
      return q[38:0];
  endfunction

  // One restoring-division step: shift the next numerator bit into the
  // partial remainder, subtract when it fits, and shift the quotient bit in.
  assign den       = (state == DIV_B) ? snap_b : snap_r;
  assign trial     = {rem, dq[NUM_W-1]};
  assign diff      = trial - {1'b0, den};
  assign q_bit     = (trial >= {1'b0, den});
  assign rem_nxt   = q_bit ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
  assign dq_nxt    = {dq[NUM_W-2:0], q_bit};
  assign last_step = (cnt == LAST_STEP);

  assign busy   = (state != IDLE);
  assign gain_g = GAIN_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall)      state_nxt = DIV_R;
      DIV_R:   if (last_step) state_nxt = DIV_B;
      DIV_B:   if (last_step) state_nxt = UPDATE;
      UPDATE:                 state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Accumulators run regardless of divider state so the next frame is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      sum_r   <= '0;
      sum_g   <= '0;
      sum_b   <= '0;
    end else begin
      vsync_d <= in_vsync;
      if (rise) begin
        sum_r <= '0;
        sum_g <= '0;
        sum_b <= '0;
      end else if (pix_en) begin
        sum_r <= sat_add(sum_r, per_img_data[23:16]);
        sum_g <= sat_add(sum_g, per_img_data[15:8]);
        sum_b <= sat_add(sum_b, per_img_data[7:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r     <= '0;
      snap_g     <= '0;
      snap_b     <= '0;
      rem        <= '0;
      dq         <= '0;
      cnt        <= '0;
      res_r      <= GAIN_ONE;
      gain_r     <= GAIN_ONE;
      gain_b     <= GAIN_ONE;
      gain_valid <= 1'b0;
    end else begin
      gain_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            snap_r <= sum_r;
            snap_g <= sum_g;
            snap_b <= sum_b;
            rem    <= '0;
            dq     <= {sum_g, 31'b0};
            cnt    <= '0;
          end
        end
        DIV_R: begin
          if (last_step) begin
            res_r <= gain_of(dq_nxt, snap_r);
            rem   <= '0;
            dq    <= {snap_g, 31'b0};
            cnt   <= '0;
          end else begin
            rem <= rem_nxt;
            dq  <= dq_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        DIV_B: begin
          rem <= rem_nxt;
          dq  <= dq_nxt;
          cnt <= last_step ? '0 : cnt + 1'b1;
        end
        UPDATE: begin
          gain_r     <= res_r;
          gain_b     <= gain_of(dq, snap_b);
          gain_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
